// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB plus HALT.
// A single shared memory port with a req/ready handshake serves both
// instruction fetch and load/store, so any number of wait states is tolerated.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       data_result,
  output logic              instr_retired,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] result_q, result_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] imm_s, imm_z;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign sa    = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign imm_s = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_z = {16'h0000, ir_q[15:0]};

  // Instruction decode and ALU evaluation for the EXEC state.
  logic [31:0] alu_res, ctrl_target;
  logic        illegal, is_ctrl, ctrl_taken, is_mem, is_sw, is_lw;

  always_comb begin
    alu_res     = '0;
    ctrl_target = pc_q;
    illegal     = 1'b0;
    is_ctrl     = 1'b0;
    ctrl_taken  = 1'b0;
    is_mem      = 1'b0;
    is_sw       = (op == OP_SW);
    is_lw       = (op == OP_LW);
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: alu_res = a_q + b_q;
          FN_SUBU: alu_res = a_q - b_q;
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
          FN_SLL:  alu_res = b_q << sa;
          FN_JR: begin
            is_ctrl     = 1'b1;
            ctrl_taken  = 1'b1;
            ctrl_target = a_q;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDIU: alu_res = a_q + imm_s;
      OP_ANDI:  alu_res = a_q & imm_z;
      OP_ORI:   alu_res = a_q | imm_z;
      OP_LW, OP_SW: begin
        alu_res = a_q + imm_s;
        is_mem  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        is_ctrl     = 1'b1;
        ctrl_taken  = (a_q == b_q) ^ (op == OP_BNE);
        // pc_q already holds pc+4 after FETCH.
        ctrl_target = pc_q + {imm_s[29:0], 2'b00};
      end
      OP_J: begin
        is_ctrl     = 1'b1;
        ctrl_taken  = 1'b1;
        ctrl_target = {pc_q[31:28], ir_q[25:0], 2'b00};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Next-state, datapath register updates and memory-port drive.
  logic        req_c, we_c, retire_c;
  logic [31:0] addr_c;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    result_d = result_q;
    rf_we    = 1'b0;
    rf_waddr = (op == OP_RTYPE) ? rd : rt;
    rf_wdata = is_lw ? mdr_q : alu_q;
    req_c    = 1'b0;
    we_c     = 1'b0;
    retire_c = 1'b0;
    addr_c   = pc_q;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = (rs == 5'd0) ? '0 : rf_q[rs];
        b_d     = (rt == 5'd0) ? '0 : rf_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (illegal) begin
          if (ILLEGAL_HALT) begin
            state_d = S_HALT;
          end else begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (is_ctrl) begin
          if (ctrl_taken) pc_d = ctrl_target;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          alu_d    = alu_res;
          result_d = alu_res;
          state_d  = is_mem ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        req_c  = 1'b1;
        we_c   = is_sw;
        addr_c = alu_q;
        if (mem_ready) begin
          if (is_sw) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset is folded into the port strobes so an in-flight transfer is
  // dropped immediately and nothing is requested while reset is held.
  assign mem_req       = req_c & ~reset;
  assign mem_we        = we_c & ~reset;
  assign mem_addr      = {addr_c[ADDR_W-1:2], 2'b00};
  assign mem_wdata     = b_q;
  assign instr_retired = retire_c & ~reset;
  assign halted        = (state_q == S_HALT);
  assign data_result   = result_q;

  // Control state and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      result_q <= result_d;
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: a vector table of straight-line
// instructions plus hand sequences for waits, control flow, halt and reset.
module tb_multi_cycle_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reset1 = 1'b1;

  logic        mem_req, mem_we, mem_ready, instr_retired, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, data_result;
  logic        mem_req1, mem_we1, mem_ready1, instr_retired1, halted1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1, data_result1;

  multi_cycle_cpu #(.RESET_PC(32'h0), .ADDR_W(32), .ILLEGAL_HALT(1'b1)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .data_result(data_result), .instr_retired(instr_retired), .halted(halted)
  );

  multi_cycle_cpu #(.RESET_PC(32'h0), .ADDR_W(32), .ILLEGAL_HALT(1'b0)) dut_nop (
    .clock(clock), .reset(reset1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_ready(mem_ready1), .mem_rdata(mem_rdata1),
    .data_result(data_result1), .instr_retired(instr_retired1), .halted(halted1)
  );

  always #5 clock = ~clock;

  // Memory model: one word array, waits only on accesses to slow_addr.
  logic [31:0] mem [256];
  logic        ld_en = 1'b0, clr = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_dat = '0;
  logic [31:0] slow_addr = 32'h8;
  int unsigned slow_wait = 0;
  int unsigned wcnt = 0;

  assign mem_ready  = mem_req && (wcnt >= ((mem_addr == slow_addr) ? slow_wait : 0));
  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem_ready1 = 1'b1;
  assign mem_rdata1 = mem[mem_addr1[9:2]];

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_idx] <= ld_dat;
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end else if (mem_req1 && mem_we1) begin
      mem[mem_addr1[9:2]] <= mem_wdata1;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic ld(input logic [7:0] idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = idx; ld_dat = d;
    @(posedge clock); #1 ld_en = 1'b0;
  endtask

  task automatic begin_test;
    @(posedge clock); #1 reset = 1'b1; reset1 = 1'b1;
    clr = 1'b1;
    @(posedge clock); #1 clr = 1'b0;
  endtask

  // Checks the reset values, then releases reset right after an edge so
  // that cycle 1 is the first FETCH cycle.
  task automatic release_reset(input logic rel1);
    @(negedge clock);
    chk("rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst data_result", data_result, 32'd0);
    chk("rst retired", {31'b0, instr_retired}, 32'd0);
    chk("rst halted", {31'b0, halted}, 32'd0);
    @(posedge clock); #1 reset = 1'b0; reset1 = ~rel1;
  endtask

  logic        we_seen;
  logic [31:0] we_addr, we_data;

  // Runs one instruction: fetch address, latency to the retire pulse,
  // result register and handshake stability while waiting.
  task automatic run_instr(input logic [31:0] exp_pc, input int exp_cyc, input bit chk_res,
                           input logic [31:0] exp_res, input string tag);
    int          cyc;
    bit          done, p_pend;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    cyc = 0; done = 1'b0; p_pend = 1'b0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk({tag, " fetch addr"}, mem_addr, exp_pc);
        chk({tag, " fetch req/we"}, {30'b0, mem_req, mem_we}, 32'd2);
      end
      if (p_pend) begin
        chk({tag, " hold addr"}, mem_addr, p_addr);
        chk({tag, " hold req/we"}, {30'b0, mem_req, mem_we}, {30'b0, 1'b1, p_we});
        chk({tag, " hold wdata"}, mem_wdata, p_wdata);
      end
      p_pend  = mem_req && !mem_ready;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
      if (mem_req && mem_we) begin
        we_seen = 1'b1; we_addr = mem_addr; we_data = mem_wdata;
      end
      if (instr_retired) done = 1'b1;
    end
    chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    if (chk_res) chk({tag, " result"}, data_result, exp_res);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
    bit          chk_res;
    logic [31:0] res;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  initial begin
    tbl[0]  = '{32'h00, enc_i(6'h09, 5'd0, 5'd1, 16'd5),       4, 1'b1, 32'd5};
    tbl[1]  = '{32'h04, enc_i(6'h09, 5'd0, 5'd2, 16'hFFFD),    4, 1'b1, 32'hFFFF_FFFD};
    tbl[2]  = '{32'h08, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21),  4, 1'b1, 32'd2};
    tbl[3]  = '{32'h0C, enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h23),  4, 1'b1, 32'hFFFF_FFF8};
    tbl[4]  = '{32'h10, enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h24),  4, 1'b1, 32'd5};
    tbl[5]  = '{32'h14, enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h25),  4, 1'b1, 32'hFFFF_FFFD};
    tbl[6]  = '{32'h18, enc_r(5'd2, 5'd1, 5'd7, 5'd0, 6'h2A),  4, 1'b1, 32'd1};
    tbl[7]  = '{32'h1C, enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h2A),  4, 1'b1, 32'd0};
    tbl[8]  = '{32'h20, enc_r(5'd0, 5'd1, 5'd9, 5'd4, 6'h00),  4, 1'b1, 32'h50};
    tbl[9]  = '{32'h24, enc_i(6'h0C, 5'd2, 5'd10, 16'hF0F0),   4, 1'b1, 32'h0000_F0F0};
    tbl[10] = '{32'h28, enc_i(6'h0D, 5'd1, 5'd11, 16'h8000),   4, 1'b1, 32'h0000_8005};
    tbl[11] = '{32'h2C, enc_i(6'h09, 5'd1, 5'd12, 16'hFFFA),   4, 1'b1, 32'hFFFF_FFFF};
    tbl[12] = '{32'h30, enc_i(6'h09, 5'd0, 5'd0, 16'd7),       4, 1'b1, 32'd7};
    tbl[13] = '{32'h34, enc_r(5'd0, 5'd0, 5'd13, 5'd0, 6'h21), 4, 1'b1, 32'd0};
    tbl[14] = '{32'h38, enc_i(6'h09, 5'd12, 5'd14, 16'd1),     4, 1'b1, 32'd0};
    tbl[15] = '{32'h3C, enc_i(6'h05, 5'd1, 5'd1, 16'd5),       3, 1'b0, 32'd0};
    tbl[16] = '{32'h40, enc_i(6'h04, 5'd1, 5'd2, 16'd5),       3, 1'b0, 32'd0};
    tbl[17] = '{32'h44, enc_r(5'd12, 5'd1, 5'd15, 5'd0, 6'h2A), 4, 1'b1, 32'd1};

    // Straight-line ALU program, zero-wait memory.
    slow_wait = 0;
    begin_test;
    for (int i = 0; i < NVEC; i++) ld(tbl[i].pc[9:2], tbl[i].instr);
    release_reset(1'b0);
    for (int i = 0; i < NVEC; i++)
      run_instr(tbl[i].pc, tbl[i].cyc, tbl[i].chk_res, tbl[i].res, $sformatf("vec%0d", i));

    // Store then load through a slow data word (3 wait cycles at 0x8).
    slow_addr = 32'h8; slow_wait = 3;
    begin_test;
    ld(8'd0, enc_i(6'h09, 5'd0, 5'd3, 16'd2));
    ld(8'd1, {6'h02, 26'h4});
    ld(8'd2, 32'hDEAD_BEEF);
    ld(8'd4, enc_i(6'h2B, 5'd0, 5'd3, 16'd8));
    ld(8'd5, enc_i(6'h23, 5'd0, 5'd4, 16'd8));
    ld(8'd6, enc_r(5'd4, 5'd0, 5'd5, 5'd0, 6'h21));
    release_reset(1'b0);
    run_instr(32'h00, 4, 1'b1, 32'd2, "ls addiu");
    run_instr(32'h04, 3, 1'b0, 32'd0, "ls j");
    we_seen = 1'b0; we_addr = '0; we_data = '0;
    run_instr(32'h10, 7, 1'b1, 32'd8, "ls sw");
    chk("sw write seen", {31'b0, we_seen}, 32'd1);
    chk("sw addr", we_addr, 32'h8);
    chk("sw wdata", we_data, 32'd2);
    run_instr(32'h14, 8, 1'b1, 32'd8, "ls lw");
    run_instr(32'h18, 4, 1'b1, 32'd2, "ls use");

    // Branches and jumps.
    slow_wait = 0;
    begin_test;
    ld(8'd3,  enc_i(6'h09, 5'd0, 5'd1, 16'd1));
    ld(8'd4,  enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    ld(8'd7,  enc_i(6'h05, 5'd1, 5'd1, 16'd2));
    ld(8'd8,  {6'h02, 26'h40});
    ld(8'd64, enc_i(6'h09, 5'd0, 5'd2, 16'h48));
    ld(8'd65, enc_r(5'd2, 5'd0, 5'd0, 5'd0, 6'h08));
    ld(8'd18, enc_i(6'h09, 5'd0, 5'd3, 16'd7));
    release_reset(1'b0);
    run_instr(32'h00, 4, 1'b1, 32'd0, "br nop0");
    run_instr(32'h04, 4, 1'b1, 32'd0, "br nop1");
    run_instr(32'h08, 4, 1'b1, 32'd0, "br nop2");
    run_instr(32'h0C, 4, 1'b1, 32'd1, "br addiu");
    run_instr(32'h10, 3, 1'b0, 32'd0, "br beq");
    run_instr(32'h1C, 3, 1'b0, 32'd0, "br bne");
    run_instr(32'h20, 3, 1'b0, 32'd0, "br j");
    run_instr(32'h100, 4, 1'b1, 32'h48, "br addiu2");
    run_instr(32'h104, 3, 1'b0, 32'd0, "br jr");
    run_instr(32'h48, 4, 1'b1, 32'd7, "br target");

    // Illegal opcode: halting core vs. NOP core side by side.
    begin_test;
    ld(8'd0, 32'hFC00_0000);
    ld(8'd1, enc_i(6'h09, 5'd0, 5'd1, 16'd9));
    release_reset(1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      chk($sformatf("ill halt retire c%0d", c), {31'b0, instr_retired}, 32'd0);
      if (c >= 4) begin
        chk($sformatf("ill halted c%0d", c), {31'b0, halted}, 32'd1);
        chk($sformatf("ill req c%0d", c), {31'b0, mem_req}, 32'd0);
      end
      chk($sformatf("nop retire c%0d", c), {31'b0, instr_retired1},
          {31'b0, (c == 3) || (c == 7)});
      if (c == 4) begin
        chk("nop fetch addr", mem_addr1, 32'h4);
        chk("nop fetch req/we", {30'b0, mem_req1, mem_we1}, 32'd2);
      end
      if (c == 7) begin
        chk("nop result", data_result1, 32'd9);
        chk("nop halted", {31'b0, halted1}, 32'd0);
      end
    end

    // Reset during a stalled load aborts it.
    slow_addr = 32'h8; slow_wait = 5;
    begin_test;
    ld(8'd0, enc_i(6'h23, 5'd0, 5'd4, 16'd8));
    ld(8'd2, 32'h0000_0055);
    release_reset(1'b0);
    repeat (4) @(negedge clock);
    chk("abort pending req/we", {30'b0, mem_req, mem_we}, 32'd2);
    chk("abort pending addr", mem_addr, 32'h8);
    chk("abort pending ready", {31'b0, mem_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort req", {31'b0, mem_req}, 32'd0);
    chk("abort retire", {31'b0, instr_retired}, 32'd0);
    ld(8'd0, enc_i(6'h09, 5'd4, 5'd5, 16'd1));
    release_reset(1'b0);
    run_instr(32'h00, 4, 1'b1, 32'd1, "abort after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
